hwag_coil_bank: RTL and testbench

- N-channel ignition coil driver for the HWAG angle path.
- Takes the master angle counter and derives a per-channel angle by adding a phase offset modulo one engine cycle.
- Switches each coil on at a programmable set angle and off at a reset angle.
- Adds what the fixed two-coil logic lacks: runtime SPI-loadable shadowed configuration, crossing-based (jump-tolerant) angle detection, and a max-dwell timeout with lockout.

---
 rtl/hwag_coil_pkg.sv | 30 +++
 rtl/hwag_coil_channel.sv | 166 ++++++++++++++++
 rtl/hwag_coil_bank.sv | 47 ++++
 tb/tb_hwag_coil_bank.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hwag_coil_pkg.sv
// Shared types and helpers for the HWAG ignition coil bank.
package hwag_coil_pkg;

  localparam logic [1:0] CFG_PHASE = 2'd0;
  localparam logic [1:0] CFG_SET   = 2'd1;
  localparam logic [1:0] CFG_RESET = 2'd2;
  localparam logic [1:0] CFG_DWELL = 2'd3;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ON      = 2'd1,
    LOCKOUT = 2'd2
  } coil_state_t;

  // True when point p lies in the half-open arc (prev, cur] of the cycle.
  function automatic logic crossed(input logic [31:0] prev,
                                   input logic [31:0] cur,
                                   input logic [31:0] p);
    logic hit;
    if (cur == prev) begin
      hit = 1'b0;
    end else if (cur > prev) begin
      hit = (p > prev) && (p <= cur);
    end else begin
      hit = (p > prev) || (p <= cur);
    end
    return hit;
  endfunction

endpackage

// File: rtl/hwag_coil_channel.sv
// One coil channel: shadowed config, phase-shifted angle, crossing detect,
// on/off/lockout FSM with max-dwell timer.
module hwag_coil_channel
  import hwag_coil_pkg::*;
#(
  parameter int unsigned ANGLE_W   = 24,
  parameter int unsigned MAX_ANGLE = 3839,
  parameter int unsigned DWELL_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hwag_start,
  input  logic [ANGLE_W-1:0] acnt,
  input  logic               acnt_vld,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_reg,
  input  logic [31:0]        cfg_data,
  input  logic               status_clr,
  output logic               coil_out,
  output logic               coil_timeout
);

  localparam int unsigned SUM_W = ANGLE_W + 1;

  logic [ANGLE_W-1:0] off_act, set_ang_act, rst_ang_act;
  logic [ANGLE_W-1:0] off_pnd, set_ang_pnd, rst_ang_pnd;
  logic [DWELL_W-1:0] dwell_act, dwell_pnd;
  logic [3:0]         pnd_flg;

  logic [ANGLE_W-1:0] ch_ang, ch_ang_nxt, prev_ang;
  logic               ch_vld, prev_vld;
  logic [SUM_W-1:0]   ang_sum;

  logic               ang_ok, wr_phase, wr_set, wr_reset, wr_dwell;
  logic               eval, set_x, reset_x, wrap, commit;

  coil_state_t        state, state_nxt;
  logic [DWELL_W-1:0] timer, timer_nxt, timer_inc;
  logic               timeout_set;

  assign ang_ok   = cfg_data <= 32'(MAX_ANGLE);
  assign wr_phase = cfg_we && (cfg_reg == CFG_PHASE) && ang_ok;
  assign wr_set   = cfg_we && (cfg_reg == CFG_SET) && ang_ok;
  assign wr_reset = cfg_we && (cfg_reg == CFG_RESET) && ang_ok;
  assign wr_dwell = cfg_we && (cfg_reg == CFG_DWELL);

  assign ang_sum    = {1'b0, acnt} + {1'b0, off_act};
  assign ch_ang_nxt = (ang_sum > SUM_W'(MAX_ANGLE))
                    ? ANGLE_W'(ang_sum - SUM_W'(MAX_ANGLE + 1))
                    : ANGLE_W'(ang_sum);

  assign eval    = ch_vld && prev_vld;
  assign set_x   = eval && crossed(32'(prev_ang), 32'(ch_ang), 32'(set_ang_act));
  assign reset_x = eval && crossed(32'(prev_ang), 32'(ch_ang), 32'(rst_ang_act));
  assign wrap    = eval && (ch_ang < prev_ang);
  assign commit  = !hwag_start || wrap;

  // Shadow registers: a write landing on a commit clock stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_act     <= '0;
      set_ang_act <= '0;
      rst_ang_act <= '0;
      dwell_act   <= '0;
      off_pnd     <= '0;
      set_ang_pnd <= '0;
      rst_ang_pnd <= '0;
      dwell_pnd   <= '0;
      pnd_flg     <= '0;
    end else begin
      if (commit) begin
        if (pnd_flg[0]) off_act     <= off_pnd;
        if (pnd_flg[1]) set_ang_act <= set_ang_pnd;
        if (pnd_flg[2]) rst_ang_act <= rst_ang_pnd;
        if (pnd_flg[3]) dwell_act   <= dwell_pnd;
        pnd_flg <= '0;
      end
      if (wr_phase) begin
        off_pnd    <= cfg_data[ANGLE_W-1:0];
        pnd_flg[0] <= 1'b1;
      end
      if (wr_set) begin
        set_ang_pnd <= cfg_data[ANGLE_W-1:0];
        pnd_flg[1]  <= 1'b1;
      end
      if (wr_reset) begin
        rst_ang_pnd <= cfg_data[ANGLE_W-1:0];
        pnd_flg[2]  <= 1'b1;
      end
      if (wr_dwell) begin
        dwell_pnd  <= cfg_data[DWELL_W-1:0];
        pnd_flg[3] <= 1'b1;
      end
    end
  end

  // Stage 1 channel angle, then previous-sample tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_ang   <= '0;
      ch_vld   <= 1'b0;
      prev_ang <= '0;
      prev_vld <= 1'b0;
    end else begin
      ch_vld <= acnt_vld;
      if (acnt_vld) ch_ang <= ch_ang_nxt;
      if (!hwag_start) begin
        prev_vld <= 1'b0;
      end else if (ch_vld) begin
        prev_ang <= ch_ang;
        prev_vld <= 1'b1;
      end
    end
  end

  assign timer_inc = timer + DWELL_W'(1);

  always_comb begin
    state_nxt   = state;
    timer_nxt   = '0;
    timeout_set = 1'b0;
    if (hwag_start) begin
      case (state)
        OFF: begin
          if (set_x && !reset_x) state_nxt = ON;
        end
        ON: begin
          timer_nxt = timer_inc;
          if (reset_x) begin
            state_nxt = OFF;
            timer_nxt = '0;
          end else if ((dwell_act != '0) && (timer_inc == dwell_act)) begin
            state_nxt   = LOCKOUT;
            timer_nxt   = '0;
            timeout_set = 1'b1;
          end
        end
        LOCKOUT: begin
          if (reset_x || wrap) state_nxt = OFF;
        end
        default: state_nxt = OFF;
      endcase
    end else begin
      state_nxt = OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= OFF;
      timer        <= '0;
      coil_out     <= 1'b0;
      coil_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      coil_out <= (state_nxt == ON);
      if (timeout_set) begin
        coil_timeout <= 1'b1;
      end else if (status_clr) begin
        coil_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hwag_coil_bank.sv
// N-channel ignition coil bank on the HWAG angle path; decodes config writes
// to the addressed channel.
module hwag_coil_bank
  import hwag_coil_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned ANGLE_W   = 24,
  parameter int unsigned MAX_ANGLE = 3839,
  parameter int unsigned DWELL_W   = 24,
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hwag_start,
  input  logic [ANGLE_W-1:0] acnt,
  input  logic               acnt_vld,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_reg,
  input  logic [31:0]        cfg_data,
  input  logic               status_clr,
  output logic [N_CH-1:0]    coil_out,
  output logic [N_CH-1:0]    coil_timeout
);

  // Channel numbers at or above N_CH match no instance and are dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    hwag_coil_channel #(
      .ANGLE_W  (ANGLE_W),
      .MAX_ANGLE(MAX_ANGLE),
      .DWELL_W  (DWELL_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .hwag_start  (hwag_start),
      .acnt        (acnt),
      .acnt_vld    (acnt_vld),
      .cfg_we      (cfg_we && (cfg_ch == CH_W'(i))),
      .cfg_reg     (cfg_reg),
      .cfg_data    (cfg_data),
      .status_clr  (status_clr),
      .coil_out    (coil_out[i]),
      .coil_timeout(coil_timeout[i])
    );
  end

endmodule

// File: tb/tb_hwag_coil_bank.sv
// Directed and randomized bench for hwag_coil_bank against an arc-based
// behavioural model of the coil bank.
module tb_hwag_coil_bank;

  localparam int NCH = 4;
  localparam int MAXA = 3839;
  localparam int L = MAXA + 1;

  logic        clk, rst, hwag_start, acnt_vld, cfg_we, status_clr;
  logic [23:0] acnt;
  logic [1:0]  cfg_ch, cfg_reg;
  logic [31:0] cfg_data;
  logic [3:0]  coil_out, coil_timeout;

  hwag_coil_bank dut (
    .clk(clk), .rst(rst), .hwag_start(hwag_start), .acnt(acnt),
    .acnt_vld(acnt_vld), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_reg(cfg_reg),
    .cfg_data(cfg_data), .status_clr(status_clr), .coil_out(coil_out),
    .coil_timeout(coil_timeout)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0, n_fail = 0;
  int hi_cnt = 0;
  int rise_at[NCH], fall_at[NCH];
  bit last[NCH];

  // Model: index 0 phase, 1 set, 2 reset, 3 dwell.
  int act[NCH][4], pval[NCH][4];
  bit pflg[NCH][4];
  bit pipe_v[NCH], pv[NCH], m_on[NCH], m_lock[NCH], m_to[NCH];
  int pipe_a[NCH], prev_a[NCH], cnt[NCH];

  // Point p is passed when its forward distance from prev is within the step.
  function automatic bit hit(int a, int b, int p);
    int d = (b - a + L) % L;
    int q = (p - a + L) % L;
    return (d != 0) && (q >= 1) && (q <= d);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int r = 0; r < 4; r++) begin act[c][r] = 0; pval[c][r] = 0; pflg[c][r] = 0; end
      pipe_v[c] = 0; pv[c] = 0; m_on[c] = 0; m_lock[c] = 0; m_to[c] = 0;
      pipe_a[c] = 0; prev_a[c] = 0; cnt[c] = 0;
    end
  endfunction

  function automatic void commit_all(int c);
    for (int r = 0; r < 4; r++) if (pflg[c][r]) begin act[c][r] = pval[c][r]; pflg[c][r] = 0; end
  endfunction

  function automatic void model_edge();
    for (int c = 0; c < NCH; c++) begin
      int nxt_a = (int'(acnt) + act[c][0]) % L;
      bit samp = pipe_v[c];
      int cur = pipe_a[c];
      bit ev = samp && pv[c];
      bit sx = ev && hit(prev_a[c], cur, act[c][1]);
      bit rx = ev && hit(prev_a[c], cur, act[c][2]);
      bit wr = ev && (cur < prev_a[c]);
      bit new_to = 0;
      if (!hwag_start) begin
        m_on[c] = 0; m_lock[c] = 0; pv[c] = 0;
        commit_all(c);
      end else begin
        if (m_on[c]) begin
          cnt[c]++;
          if (rx) m_on[c] = 0;
          else if (act[c][3] != 0 && cnt[c] == act[c][3]) begin
            m_on[c] = 0; m_lock[c] = 1; new_to = 1;
          end
        end else if (m_lock[c]) begin
          if (rx || wr) m_lock[c] = 0;
        end else if (sx && !rx) begin
          m_on[c] = 1; cnt[c] = 0;
        end
        if (samp) begin prev_a[c] = cur; pv[c] = 1; end
        if (wr) commit_all(c);
      end
      if (cfg_we && int'(cfg_ch) == c && (cfg_reg == 2'd3 || cfg_data <= 32'(MAXA))) begin
        pval[c][cfg_reg] = (cfg_reg == 2'd3) ? int'(cfg_data & 32'h00FF_FFFF) : int'(cfg_data);
        pflg[c][cfg_reg] = 1;
      end
      if (new_to) m_to[c] = 1;
      else if (status_clr) m_to[c] = 0;
      pipe_v[c] = acnt_vld;
      pipe_a[c] = nxt_a;
    end
  endfunction

  function automatic logic [3:0] exp_coil();
    logic [3:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_on[c];
    return v;
  endfunction

  function automatic logic [3:0] exp_to();
    logic [3:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_to[c];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    if (coil_out[0]) hi_cnt++;
    chk("coil_out", 32'(coil_out), 32'(exp_coil()));
    chk("coil_timeout", 32'(coil_timeout), 32'(exp_to()));
  endtask

  task automatic write(input int ch, input int r, input int data);
    cfg_we = 1; cfg_ch = 2'(ch); cfg_reg = 2'(r); cfg_data = 32'(data);
    tick();
    cfg_we = 0;
  endtask

  task automatic strobe_g(input int a, input int gap);
    acnt = 24'(a); acnt_vld = 1;
    tick();
    acnt_vld = 0;
    repeat (gap - 1) tick();
    for (int c = 0; c < NCH; c++) begin
      if (coil_out[c] && !last[c]) rise_at[c] = a;
      if (!coil_out[c] && last[c]) fall_at[c] = a;
      last[c] = coil_out[c];
    end
  endtask

  task automatic strobe(input int a);
    strobe_g(a, 4);
  endtask

  initial begin
    int a;
    clk = 0; rst = 1; hwag_start = 0; acnt_vld = 0; cfg_we = 0; status_clr = 0;
    acnt = '0; cfg_ch = '0; cfg_reg = '0; cfg_data = '0;
    model_reset();
    for (int c = 0; c < NCH; c++) begin rise_at[c] = -1; fall_at[c] = -1; last[c] = 0; end
    tick(); tick();
    chk("reset_coil", 32'(coil_out), 32'd0);
    chk("reset_timeout", 32'(coil_timeout), 32'd0);
    rst = 0;

    // Two channels, slow sweep across the set/reset points.
    write(0, 0, 0); write(0, 1, 3000); write(0, 2, 3839);
    write(1, 0, 1920); write(1, 1, 1000); write(1, 2, 1100);
    tick();
    hwag_start = 1;
    for (int i = 2900; i <= 3839; i++) strobe(i);
    chk("ch0_rise", 32'(rise_at[0]), 32'd3000);
    chk("ch0_fall", 32'(fall_at[0]), 32'd3839);
    chk("ch1_rise", 32'(rise_at[1]), 32'd2920);
    chk("ch1_fall", 32'(fall_at[1]), 32'd3020);
    chk("sweep_no_timeout", 32'(coil_timeout), 32'd0);

    // Jump over set, then over reset.
    hwag_start = 0;
    write(0, 1, 50); write(0, 2, 60); tick();
    hwag_start = 1;
    strobe(40); strobe(55);
    chk("jump_on", 32'(coil_out[0]), 32'd1);
    strobe(70);
    chk("jump_off", 32'(coil_out[0]), 32'd0);

    // Set and reset in the same jump: reset wins.
    hwag_start = 0;
    write(0, 2, 52); tick();
    hwag_start = 1;
    strobe(40); strobe(55);
    chk("both_crossed", 32'(coil_out[0]), 32'd0);

    // Max dwell lockout, then refire after the wrap.
    hwag_start = 0;
    write(0, 1, 10); write(0, 2, 3000); write(0, 3, 100); tick();
    hwag_start = 1;
    hi_cnt = 0;
    for (int i = 5; i <= 40; i++) strobe(i);
    chk("dwell_clks", 32'(hi_cnt), 32'd100);
    chk("dwell_timeout", 32'(coil_timeout[0]), 32'd1);
    chk("lockout_off", 32'(coil_out[0]), 32'd0);
    strobe(3001); strobe(3839); strobe(0); strobe(15);
    chk("refire", 32'(coil_out[0]), 32'd1);
    status_clr = 1; tick(); status_clr = 0;
    chk("status_clr", 32'(coil_timeout[0]), 32'd0);

    // Set written mid-cycle takes effect only after the wrap.
    hwag_start = 0;
    write(0, 1, 10); write(0, 2, 20); write(0, 3, 0); tick();
    hwag_start = 1;
    strobe(5); strobe(15);
    chk("old_set_on", 32'(coil_out[0]), 32'd1);
    write(0, 1, 2000);
    strobe(25);
    chk("reset_off", 32'(coil_out[0]), 32'd0);
    strobe(1999); strobe(2001);
    chk("pending_unused", 32'(coil_out[0]), 32'd0);
    strobe(3839); strobe(0); strobe(15);
    chk("old_set_gone", 32'(coil_out[0]), 32'd0);
    strobe(1999); strobe(2001);
    chk("new_set_on", 32'(coil_out[0]), 32'd1);

    // Out-of-range write ignored; hwag_start drop forces off next clk.
    write(0, 1, 3840);
    hwag_start = 0; tick();
    chk("start_drop", 32'(coil_out[0]), 32'd0);
    hwag_start = 1;
    strobe(1990); strobe(2010);
    chk("bad_write_ignored", 32'(coil_out[0]), 32'd1);

    // Asynchronous reset mid-dwell.
    #3 rst = 1;
    #1;
    chk("async_rst_coil", 32'(coil_out), 32'd0);
    chk("async_rst_timeout", 32'(coil_timeout), 32'd0);
    model_reset();
    tick();
    rst = 0;

    // Randomized traffic.
    a = 0;
    for (int it = 0; it < 900; it++) begin
      int r = $urandom_range(0, 99);
      if (r < 15) begin
        int rg = $urandom_range(0, 3);
        int d;
        if (rg == 3) d = $urandom_range(0, 300);
        else if ($urandom_range(0, 9) == 0) d = $urandom_range(3840, 5000);
        else d = $urandom_range(0, MAXA);
        write($urandom_range(0, 3), rg, d);
      end else if (r < 18) begin
        hwag_start = 0; tick(); hwag_start = 1;
      end else if (r < 22) begin
        status_clr = 1; tick(); status_clr = 0;
      end else begin
        if ($urandom_range(0, 19) == 0) a = $urandom_range(0, MAXA);
        else a = (a + $urandom_range(0, 60)) % L;
        strobe_g(a, $urandom_range(1, 4));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
